// File: rtl/ram_burst_if.sv
// Command, write, read and RAM pin bundle for ram_burst_ctrl.
// slave = controller side, master = traffic/RAM side.
interface ram_burst_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_datain;
  logic [DATA_WIDTH-1:0] ram_dataout;
  logic                  ram_cs;
  logic                  ram_we;
  logic                  ram_oe;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready, ram_dataout,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output ram_address, ram_datain, ram_cs, ram_we, ram_oe,
    output busy, done, err
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready, ram_dataout,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  ram_address, ram_datain, ram_cs, ram_we, ram_oe,
    input  busy, done, err
  );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst read/write controller for a synchronous single-port RAM.
// Define RAM_BURST_BOUND_CHK_EN to reject bursts crossing the top address.
module ram_burst_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  ram_burst_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_ZERO = '0;
  localparam logic [DATA_WIDTH-1:0] D_ZERO = '0;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [1:0]            occ_q, occ_d;
  logic                  rptr_q, rptr_d;
  logic                  wptr_q, wptr_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];

  logic       wr_hs;
  logic       issue;
  logic       push;
  logic       pop;
  logic       last_pop;
  logic [1:0] pend;

`ifdef RAM_BURST_BOUND_CHK_EN
  logic [ADDR_WIDTH:0] span;
  logic                oob;
  assign span = {1'b0, bus.cmd_addr} + {1'b0, bus.cmd_len};
  assign oob  = span[ADDR_WIDTH];
`endif

  // A read is only issued when its word is sure to find a FIFO slot.
  assign pend  = occ_q + {1'b0, inflight_q};
  assign wr_hs = (state_q == WRITE) && bus.wr_valid;
  assign issue = (state_q == READ) && (pend < 2'd2);
  assign push  = inflight_q;
  assign pop   = (occ_q != 2'd0) && bus.rd_ready;

  assign last_pop = (state_q == DRAIN) && !inflight_q
                  && (occ_q == 2'd1) && pop;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    inflight_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d = bus.cmd_addr;
          cnt_d  = bus.cmd_len;
`ifdef RAM_BURST_BOUND_CHK_EN
          if (oob)
            err_d = 1'b1;
          else
            state_d = bus.cmd_write ? WRITE : READ;
`else
          state_d = bus.cmd_write ? WRITE : READ;
`endif
        end
      end
      WRITE: begin
        if (wr_hs) begin
          addr_d = addr_q + A_ONE;
          if (cnt_q == A_ZERO) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - A_ONE;
          end
        end
      end
      READ: begin
        inflight_d = issue;
        if (issue) begin
          addr_d = addr_q + A_ONE;
          if (cnt_q == A_ZERO)
            state_d = DRAIN;
          else
            cnt_d = cnt_q - A_ONE;
        end
      end
      DRAIN: begin
        if (last_pop)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output FIFO: the word captured now is the one issued last cycle.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q] = bus.ram_dataout;
      wptr_d        = ~wptr_q;
    end
    if (pop)
      rptr_d = ~rptr_q;
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      occ_q      <= 2'd0;
      rptr_q     <= 1'b0;
      wptr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      err_q      <= err_d;
      occ_q      <= occ_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.wr_ready    = (state_q == WRITE);
  assign bus.ram_cs      = wr_hs || issue || inflight_q;
  assign bus.ram_we      = wr_hs;
  assign bus.ram_oe      = issue || inflight_q;
  assign bus.ram_address = (state_q == IDLE) ? A_ZERO : addr_q;
  assign bus.ram_datain  = wr_hs ? bus.wr_data : D_ZERO;
  assign bus.rd_valid    = (occ_q != 2'd0);
  assign bus.rd_data     = bus.rd_valid ? mem_q[rptr_q] : D_ZERO;
  assign bus.busy        = (state_q != IDLE) || (occ_q != 2'd0);
  assign bus.done        = done_q || last_pop;
  assign bus.err         = err_q;

endmodule

// File: doc/ram_burst_ctrl.md
RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, RAM address width; RAM_DEPTH = 2^ADDR_WIDTH.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when valid&&ready.
- cmd_write  input  1  1=write burst, 0=read burst.
- cmd_addr  input  ADDR_WIDTH  burst start address.
- cmd_len  input  ADDR_WIDTH  burst length minus one.
- wr_valid  input  1  write word offered.
- wr_ready  output  1  write word accepted.
- wr_data  input  DATA_WIDTH  write word.
- rd_valid  output  1  read word available.
- rd_ready  input  1  consumer accepts read word.
- rd_data  output  DATA_WIDTH  read word.
- ram_address  output  ADDR_WIDTH  RAM address.
- ram_datain  output  DATA_WIDTH  RAM write data.
- ram_dataout  input  DATA_WIDTH  RAM read data; valid one cycle after read issue while cs, oe high and we low.
- ram_cs, ram_we, ram_oe  output  1 each  RAM chip select, write enable, output enable.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst completion.
- err  output  1  one-cycle pulse on rejected command.

Function
REQ-004 SHALL implement states IDLE, WRITE, READ, DRAIN.
REQ-005 cmd_ready SHALL be 1 only in IDLE; acceptance latches addr/len/dir and moves to WRITE or READ next cycle.
REQ-006 WRITE: wr_ready=1; each wr handshake SHALL drive ram_cs=1, ram_we=1, ram_oe=0, ram_address=current addr, ram_datain=wr_data in that same cycle; no handshake -> ram_cs=0.
REQ-007 Address SHALL increment by 1 per transferred word, modulo RAM_DEPTH (wrap 2^ADDR_WIDTH-1 -> 0).
REQ-008 WRITE SHALL end after cmd_len+1 handshakes: done pulses the cycle after the last write, state returns to IDLE.
REQ-009 READ: a read is issued (ram_cs=1, ram_oe=1, ram_we=0) only if output buffer occupancy plus in-flight reads < 2.
REQ-010 ram_dataout SHALL be captured into a 2-entry output FIFO exactly one cycle after each issue; ram_cs/ram_oe SHALL stay 1 and ram_we 0 during that capture cycle.
REQ-011 After the final issue, state SHALL go to DRAIN, holding ram_cs=1, ram_oe=1, ram_we=0 for one capture cycle; the extra RAM read is discarded.
REQ-012 rd_valid SHALL be 1 whenever the FIFO is non-empty; rd_data = head entry; pops on rd_valid&&rd_ready; simultaneous push and pop SHALL be allowed.
REQ-013 Read done SHALL pulse the cycle the last word is popped; return to IDLE same time; busy=0 only in IDLE with empty FIFO.
REQ-014 Read words SHALL emerge in address order with no loss or duplication under any rd_ready pattern.
REQ-015 ram_we and ram_oe SHALL never both be 1.
REQ-016 cmd_len=0 SHALL yield a single-word burst.

Reset
REQ-017 rst_n=0 at a clock edge SHALL force IDLE, empty FIFO, zero in-flight, and outputs cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, ram_cs=0, ram_we=0, ram_oe=0, ram_address=0, ram_datain=0, busy=0, done=0, err=0.
REQ-018 Reset mid-burst SHALL abandon the burst with no done pulse; pending read data is dropped.

Configuration
REQ-019 Macro RAM_BURST_BOUND_CHK_EN defined: a command with cmd_addr+cmd_len > RAM_DEPTH-1 SHALL be consumed (handshake completes), pulse err next cycle, stay IDLE, no RAM access.
REQ-020 Macro undefined: such commands SHALL execute with wrap per REQ-007; err SHALL be constant 0.

Verification
REQ-021 Write addr=0x10, len=3, data 0xA0..0xA3 -> four cycles ram_cs=1, ram_we=1, addresses 0x10..0x13, then done.
REQ-022 Read back addr=0x10, len=3, rd_ready=1 -> rd_data 0xA0,0xA1,0xA2,0xA3 in order; done on last pop.
REQ-023 Read len=7 with rd_ready toggling 1-0-0-1 -> all 8 words in order, FIFO never exceeds 2, no duplicates.
REQ-024 Write addr=0xFE, len=2 without macro -> addresses 0xFE, 0xFF, 0x00; with macro -> err pulse, ram_cs stays 0.
REQ-025 rst_n=0 during word 2 of a 4-word read -> next cycle all outputs at reset values, no done; following command executes normally.
REQ-026 Write len=0 with wr_valid delayed 5 cycles -> ram_cs=0 for 5 cycles, then one write, done next cycle.
